axis_div_iter: RTL and testbench

- Parametrised iterative radix-2 restoring divider with AXI4-Stream style divisor, dividend and result channels.
- Replaces the fixed 32-bit, unsigned, no-backpressure divider core.
- Adds:
  - WIDTH parametrisation
  - per-operation signed/unsigned mode
  - result-channel backpressure
  - defined divide-by-zero and signed-overflow results
- Sits between the execute stage and writeback as a multi-cycle functional unit.

---
 rtl/axis_div_iter.sv | 206 ++++++++++++++++++++
 tb/tb_axis_div_iter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_div_iter.sv
// Iterative radix-2 restoring divider with AXI4-Stream divisor/dividend/result channels.
// Optional result flags on m_axis_dout_tuser are enabled by defining AXIS_DIV_FLAGS_EN.
module axis_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_dividend_tuser,
    output logic               m_axis_dout_tvalid,
    input  logic               m_axis_dout_tready,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata
`ifdef AXIS_DIV_FLAGS_EN
    ,
    output logic [1:0]         m_axis_dout_tuser
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_COLLECT,
        S_PREP,
        S_ITER,
        S_FIX,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic               mode_q, mode_d;
    logic               dvs_full_q, dvs_full_d;
    logic               dvd_full_q, dvd_full_d;
    logic               dvs_rdy_q, dvs_rdy_d;
    logic               dvd_rdy_q, dvd_rdy_d;
    logic [WIDTH-1:0]   abs_dvs_q, abs_dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;
`ifdef AXIS_DIV_FLAGS_EN
    logic [1:0]         flags_q, flags_d;
`endif

    logic               hs_dvs, hs_dvd;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic               div0, ovf;

    assign hs_dvs = s_axis_divisor_tvalid && dvs_rdy_q;
    assign hs_dvd = s_axis_dividend_tvalid && dvd_rdy_q;

    // Trial subtract in WIDTH+1 bits: the MSB is the sign of the difference.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, abs_dvs_q};

    assign q_fix = q_neg_q ? -quo_q : quo_q;
    assign r_fix = r_neg_q ? -rem_q : rem_q;
    assign div0  = (dvs_q == '0);
    assign ovf   = mode_q && (dvd_q == MIN_VAL) && (dvs_q == '1);

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path through this block can infer a latch.
        state_d    = state_q;
        dvs_d      = dvs_q;
        dvd_d      = dvd_q;
        mode_d     = mode_q;
        dvs_full_d = dvs_full_q;
        dvd_full_d = dvd_full_q;
        abs_dvs_d  = abs_dvs_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dout_d     = dout_q;
`ifdef AXIS_DIV_FLAGS_EN
        flags_d    = flags_q;
`endif

        case (state_q)
            S_COLLECT: begin
                if (hs_dvs) begin
                    dvs_d      = s_axis_divisor_tdata;
                    dvs_full_d = 1'b1;
                end
                if (hs_dvd) begin
                    dvd_d      = s_axis_dividend_tdata;
                    mode_d     = s_axis_dividend_tuser;
                    dvd_full_d = 1'b1;
                end
                if (dvs_full_d && dvd_full_d) state_d = S_PREP;
            end
            S_PREP: begin
                if (mode_q) begin
                    abs_dvs_d = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                    quo_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
                    q_neg_d   = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                    r_neg_d   = dvd_q[WIDTH-1];
                end else begin
                    abs_dvs_d = dvs_q;
                    quo_d     = dvd_q;
                    q_neg_d   = 1'b0;
                    r_neg_d   = 1'b0;
                end
                rem_d   = '0;
                cnt_d   = CNT_W'(WIDTH);
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (div0)     dout_d = {{WIDTH{1'b1}}, dvd_q};
                else if (ovf) dout_d = {MIN_VAL, {WIDTH{1'b0}}};
                else          dout_d = {q_fix, r_fix};
`ifdef AXIS_DIV_FLAGS_EN
                flags_d = {div0, ovf};
`endif
                state_d = S_OUT;
            end
            S_OUT: begin
                if (m_axis_dout_tready) begin
                    dvs_full_d = 1'b0;
                    dvd_full_d = 1'b0;
                    state_d    = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase

        // Readies are registered so they stay low through reset and rise one edge later.
        dvs_rdy_d = (state_d == S_COLLECT) && !dvs_full_d;
        dvd_rdy_d = (state_d == S_COLLECT) && !dvd_full_d;
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
        if (areset) begin
            state_q    <= S_COLLECT;
            dvs_q      <= '0;
            dvd_q      <= '0;
            mode_q     <= 1'b0;
            dvs_full_q <= 1'b0;
            dvd_full_q <= 1'b0;
            dvs_rdy_q  <= 1'b0;
            dvd_rdy_q  <= 1'b0;
            abs_dvs_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dout_q     <= '0;
`ifdef AXIS_DIV_FLAGS_EN
            flags_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dvs_q      <= dvs_d;
            dvd_q      <= dvd_d;
            mode_q     <= mode_d;
            dvs_full_q <= dvs_full_d;
            dvd_full_q <= dvd_full_d;
            dvs_rdy_q  <= dvs_rdy_d;
            dvd_rdy_q  <= dvd_rdy_d;
            abs_dvs_q  <= abs_dvs_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dout_q     <= dout_d;
`ifdef AXIS_DIV_FLAGS_EN
            flags_q    <= flags_d;
`endif
        end
    end

    assign s_axis_divisor_tready  = dvs_rdy_q;
    assign s_axis_dividend_tready = dvd_rdy_q;
    assign m_axis_dout_tvalid     = (state_q == S_OUT);
    assign m_axis_dout_tdata      = dout_q;
`ifdef AXIS_DIV_FLAGS_EN
    assign m_axis_dout_tuser      = flags_q;
`endif

endmodule

// File: tb/tb_axis_div_iter.sv
// Scoreboard bench for axis_div_iter (WIDTH=32): stimulus pushes model results, a monitor pops on each output beat.
module tb_axis_div_iter;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [1:0]   f;
    } exp_t;

    logic           aclk = 1'b0;
    logic           areset = 1'b1;
    logic           dvs_valid = 1'b0;
    logic           dvs_ready;
    logic [W-1:0]   dvs_data = '0;
    logic           dvd_valid = 1'b0;
    logic           dvd_ready;
    logic [W-1:0]   dvd_data = '0;
    logic           dvd_user = 1'b0;
    logic           dout_valid;
    logic           dout_ready = 1'b1;
    logic [2*W-1:0] dout_data;
`ifdef AXIS_DIV_FLAGS_EN
    logic [1:0]     dout_user;
`endif

    axis_div_iter #(.WIDTH(W)) dut (
        .aclk                   (aclk),
        .areset                 (areset),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_dividend_tuser  (dvd_user),
        .m_axis_dout_tvalid     (dout_valid),
        .m_axis_dout_tready     (dout_ready),
        .m_axis_dout_tdata      (dout_data)
`ifdef AXIS_DIV_FLAGS_EN
        ,
        .m_axis_dout_tuser      (dout_user)
`endif
    );

    always #5 aclk = ~aclk;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   dvs_hs_cyc = 0;
    int   dvd_hs_cyc = 0;
    int   out_hs_cyc = 0;
    exp_t sb[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain SV arithmetic (truncating division, remainder follows dividend) plus the defined special cases.
    function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic mode);
        exp_t e;
        if (dvs == '0) begin
            e.q = '1;
            e.r = dvd;
            e.f = 2'b10;
        end else if (mode && dvd == 32'h8000_0000 && dvs == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
            e.f = 2'b01;
        end else if (mode) begin
            e.q = $signed(dvd) / $signed(dvs);
            e.r = $signed(dvd) % $signed(dvs);
            e.f = 2'b00;
        end else begin
            e.q = dvd / dvs;
            e.r = dvd % dvs;
            e.f = 2'b00;
        end
        return e;
    endfunction

    // Monitor: pop and compare on every accepted output beat.
    always @(negedge aclk) begin
        if (!areset && dout_valid && dout_ready) begin
            out_hs_cyc = cyc + 1;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: tdata=0x%0h with empty scoreboard", dout_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dout_quotient", {32'h0, dout_data[2*W-1:W]}, {32'h0, e.q});
                check("dout_remainder", {32'h0, dout_data[W-1:0]}, {32'h0, e.r});
`ifdef AXIS_DIV_FLAGS_EN
                check("dout_flags", {62'h0, dout_user}, {62'h0, e.f});
`endif
            end
        end
    end

    // gap > 0: divisor first by gap cycles; gap < 0: dividend first; 0: same cycle.
    task automatic issue(input logic [W-1:0] dvs, input logic [W-1:0] dvd, input logic mode,
                         input int gap, input bit expect_out);
        int t_dvs = (gap < 0) ? -gap : 0;
        int t_dvd = (gap > 0) ? gap : 0;
        bit s_done = 1'b0;
        bit d_done = 1'b0;
        bit hs_s, hs_d;
        for (int c = 0; c < 400 && !(s_done && d_done); c++) begin
            if (!s_done) begin
                if (c >= t_dvs) begin dvs_valid = 1'b1; dvs_data = dvs; end
                else dvs_data = $urandom;
            end
            if (!d_done) begin
                if (c >= t_dvd) begin dvd_valid = 1'b1; dvd_data = dvd; dvd_user = mode; end
                else begin dvd_data = $urandom; dvd_user = 1'($urandom); end
            end
            hs_s = dvs_valid && dvs_ready;
            hs_d = dvd_valid && dvd_ready;
            @(posedge aclk); #1;
            if (hs_s) begin s_done = 1'b1; dvs_valid = 1'b0; dvs_data = $urandom; dvs_hs_cyc = cyc; end
            if (hs_d) begin d_done = 1'b1; dvd_valid = 1'b0; dvd_data = $urandom; dvd_hs_cyc = cyc; end
        end
        check("issue_accepted", {62'h0, s_done, d_done}, 64'h3);
        if (expect_out) sb.push_back(model(dvd, dvs, mode));
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || dout_valid) && k < 300) begin
            @(posedge aclk); #1;
            k++;
        end
        check("drain_in_time", {63'h0, k < 300}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit saw, stable, rdy_low;
        logic [2*W-1:0] held;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_dvs_ready", {63'h0, dvs_ready}, 64'h0);
        check("rst_dvd_ready", {63'h0, dvd_ready}, 64'h0);
        check("rst_tvalid", {63'h0, dout_valid}, 64'h0);
        check("rst_tdata", dout_data, 64'h0);
`ifdef AXIS_DIV_FLAGS_EN
        check("rst_tuser", {62'h0, dout_user}, 64'h0);
`endif
        areset = 1'b0;
        check("ready_before_edge", {62'h0, dvs_ready, dvd_ready}, 64'h0);
        @(posedge aclk); #1;
        check("ready_after_edge", {62'h0, dvs_ready, dvd_ready}, 64'h3);

        // Unsigned basic with latency measurement
        issue(32'h11, 32'h2222, 1'b0, 2, 1'b1);
        k = 0;
        while (!dout_valid && k < 100) begin @(posedge aclk); #1; k++; end
        check("latency", 64'(cyc - dvd_hs_cyc), 64'(W + 2));
        drain();

        // Signed sign rules and special cases
        issue(32'd2, -32'sd7, 1'b1, 0, 1'b1);
        issue(-32'sd2, 32'd7, 1'b1, 1, 1'b1);
        issue(32'd0, 32'd5, 1'b1, 0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, 1'b1);
        issue(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 1'b1);
        drain();

        // Backpressure with a queued operation waiting at the inputs
        dout_ready = 1'b0;
        issue(32'd3, 32'd1000, 1'b0, 0, 1'b1);
        fork
            issue(32'd7, -32'sd100, 1'b1, 0, 1'b1);
            begin
                k = 0;
                while (!dout_valid && k < 100) begin @(posedge aclk); #1; k++; end
                held = dout_data;
                stable = 1'b1;
                rdy_low = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(posedge aclk); #1;
                    if (dout_data !== held || !dout_valid) stable = 1'b0;
                    if (dvs_ready || dvd_ready) rdy_low = 1'b0;
                end
                check("bp_tdata_stable", {63'h0, stable}, 64'h1);
                check("bp_readies_low", {63'h0, rdy_low}, 64'h1);
                dout_ready = 1'b1;
            end
        join
        check("bp_next_dvs_edge", 64'(dvs_hs_cyc), 64'(out_hs_cyc + 1));
        check("bp_next_dvd_edge", 64'(dvd_hs_cyc), 64'(out_hs_cyc + 1));
        drain();

        // Ordering and simultaneity
        issue(32'h1234, 32'h1234_5678, 1'b0, -3, 1'b1);
        drain();
        k = cyc;
        issue(32'd9, 32'd1000, 1'b1, 0, 1'b1);
        check("simul_same_edge", 64'(dvs_hs_cyc), 64'(dvd_hs_cyc));
        check("simul_first_edge", 64'(dvd_hs_cyc), 64'(k + 1));
        drain();

        // Back-to-back random operations
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(1, 20);
                1: b = -($urandom_range(1, 20));
                2: b = (i == 5) ? 32'h0 : $urandom;
                default: b = $urandom >> $urandom_range(0, 28);
            endcase
            issue(b, a, 1'($urandom), $urandom_range(0, 4) - 2, 1'b1);
        end
        drain();

        // Reset in the middle of the iteration phase
        issue(32'd13, 32'd999_999, 1'b0, 0, 1'b0);
        repeat (11) @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        check("midrst_readies_low", {62'h0, dvs_ready, dvd_ready}, 64'h0);
        areset = 1'b0;
        @(posedge aclk); #1;
        check("midrst_readies_high", {62'h0, dvs_ready, dvd_ready}, 64'h3);
        saw = 1'b0;
        for (int i = 0; i < W + 10; i++) begin
            if (dout_valid) saw = 1'b1;
            @(posedge aclk); #1;
        end
        check("midrst_no_output", {63'h0, saw}, 64'h0);
        issue(32'd7, 32'd100, 1'b0, 0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
